regfile_sb: RTL and testbench



---
 rtl/regfile_sb.sv | 127 ++++++++++++
 tb/tb_regfile_sb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write-to-read bypass and a
// per-register pending scoreboard used by decode to stall on RAW hazards.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset_n   - synchronous active-low reset (clears registers and scoreboard)
//   rd_addr   - NUM_RD packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data   - NUM_RD packed read data, port p at [p*DATA_W +: DATA_W]
//   rd_ready  - per read port, 1 = register has no outstanding producer
//   wr_en     - writeback strobe
//   wr_addr   - writeback register
//   wr_data   - writeback data
//   iss_en    - issue strobe, marks iss_addr pending
//   iss_addr  - destination register of the issuing instruction
//   pending   - registered scoreboard bitmap, bit r = register r awaits writeback
module regfile_sb #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int ZERO_EN   = 1,
  parameter int ZERO_IDX  = 31,
  parameter int BYPASS_EN = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [DEPTH-1:0]         pending
);

  // DEPTH may equal 2**ADDR_W, so the bound needs one extra bit.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_IDX);
  localparam bit                ZERO_ON = (ZERO_EN != 0);
  localparam bit                BYP_ON  = (BYPASS_EN != 0);

  function automatic logic is_valid(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_ON && (a == ZERO_A);
  endfunction

  function automatic logic is_writable(input logic [ADDR_W-1:0] a);
    return is_valid(a) && !is_zero(a);
  endfunction

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic              wr_ok;
  logic              iss_ok;

  assign wr_ok   = wr_en  && is_writable(wr_addr);
  assign iss_ok  = iss_en && is_writable(iss_addr);
  assign pending = pending_q;

  // The zero register is never writable or issuable, so it stays at its
  // reset value of 0 and its pending bit stays clear. Issue is applied after
  // write so a same-cycle write+issue leaves the register pending.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
      pending_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_ok && (wr_addr == ADDR_W'(r))) begin
          regs[r]      <= wr_data;
          pending_q[r] <= 1'b0;
        end
        if (iss_ok && (iss_addr == ADDR_W'(r))) begin
          pending_q[r] <= 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;
    logic              stored_pend;
    logic [DATA_W-1:0] data_p;
    logic              ready_p;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      stored      = '0;
      stored_pend = 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
        if (addr == ADDR_W'(r)) begin
          stored      = regs[r];
          stored_pend = pending_q[r];
        end
      end
    end

    // Forwarded data is the newest value, so it is ready even if the same
    // register is being re-issued this cycle. No forwarding during reset.
    always_comb begin
      data_p  = '0;
      ready_p = 1'b1;
      if (is_valid(addr) && !is_zero(addr)) begin
        if (BYP_ON && reset_n && wr_en && (wr_addr == addr)) begin
          data_p  = wr_data;
          ready_p = 1'b1;
        end else begin
          data_p  = stored;
          ready_p = ~stored_pend;
        end
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = data_p;
    assign rd_ready[p]                 = ready_p;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: checks regfile_sb in its default configuration (with and
// without bypass, driven by identical stimulus) against an array-based
// reference model, plus a directed run of a 32-bit/16-entry/3-port variant
// without a zero register.
module tb_regfile_sb;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the default and no-bypass instances.
  logic         reset_n;
  logic [9:0]   rd_addr;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         iss_en;
  logic [4:0]   iss_addr;

  logic [127:0] a_rd_data,  b_rd_data;
  logic [1:0]   a_rd_ready, b_rd_ready;
  logic [31:0]  a_pending,  b_pending;

  regfile_sb u_dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(a_rd_data),
    .rd_ready(a_rd_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .pending(a_pending)
  );

  regfile_sb #(.BYPASS_EN(0)) u_nobyp (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .rd_ready(b_rd_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .pending(b_pending)
  );

  // Sweep instance: 32-bit data, 16 registers, 3 read ports, no zero register.
  logic         s_reset_n;
  logic [14:0]  s_rd_addr;
  logic         s_wr_en;
  logic [4:0]   s_wr_addr;
  logic [31:0]  s_wr_data;
  logic         s_iss_en;
  logic [4:0]   s_iss_addr;
  logic [95:0]  s_rd_data;
  logic [2:0]   s_rd_ready;
  logic [15:0]  s_pending;

  regfile_sb #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .NUM_RD(3), .ZERO_EN(0)) u_sweep (
    .clk(clk), .reset_n(s_reset_n), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .rd_ready(s_rd_ready), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .iss_en(s_iss_en), .iss_addr(s_iss_addr), .pending(s_pending)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the default configuration: plain architectural state.
  logic [63:0] m_reg  [32];
  bit          m_pend [32];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit m_writable(input int a);
    return (a < 32) && (a != 31);
  endfunction

  function automatic void m_read(input int a, input bit byp, output logic [63:0] d, output bit rdy);
    if (a >= 32 || a == 31) begin
      d = '0; rdy = 1'b1;
    end else if (byp && reset_n && wr_en && int'(wr_addr) == a) begin
      d = wr_data; rdy = 1'b1;
    end else begin
      d = m_reg[a]; rdy = !m_pend[a];
    end
  endfunction

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  task automatic applyStimulus(input bit rst, input int a0, input int a1,
                               input bit we, input int wa, input logic [63:0] wd,
                               input bit ie, input int ia);
    reset_n  = rst;
    rd_addr  = {5'(a1), 5'(a0)};
    wr_en    = we;
    wr_addr  = 5'(wa);
    wr_data  = wd;
    iss_en   = ie;
    iss_addr = 5'(ia);
  endtask

  task automatic check_model_reads();
    logic [63:0] d;
    bit          rdy;
    for (int p = 0; p < 2; p++) begin
      m_read(int'(rd_addr[p*5 +: 5]), 1'b1, d, rdy);
      checkOutput($sformatf("byp_data%0d", p), a_rd_data[p*64 +: 64], d);
      checkOutput($sformatf("byp_rdy%0d", p), 64'(a_rd_ready[p]), 64'(rdy));
      m_read(int'(rd_addr[p*5 +: 5]), 1'b0, d, rdy);
      checkOutput($sformatf("nobyp_data%0d", p), b_rd_data[p*64 +: 64], d);
      checkOutput($sformatf("nobyp_rdy%0d", p), 64'(b_rd_ready[p]), 64'(rdy));
    end
  endtask

  // Advance one edge, update the model the way the spec describes, then
  // compare both scoreboards.
  task automatic clock_edge();
    @(posedge clk);
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[r] = '0; m_pend[r] = 1'b0;
      end
    end else begin
      if (wr_en && m_writable(int'(wr_addr))) begin
        m_reg[wr_addr] = wr_data; m_pend[wr_addr] = 1'b0;
      end
      if (iss_en && m_writable(int'(iss_addr))) m_pend[iss_addr] = 1'b1;
    end
    #1;
    checkOutput("byp_pending", 64'(a_pending), 64'(m_pend_vec()));
    checkOutput("nobyp_pending", 64'(b_pending), 64'(m_pend_vec()));
  endtask

  task automatic step(input bit rst, input int a0, input int a1,
                      input bit we, input int wa, input logic [63:0] wd,
                      input bit ie, input int ia);
    applyStimulus(rst, a0, a1, we, wa, wd, ie, ia);
    #2;
    check_model_reads();
    clock_edge();
  endtask

  task automatic sweep_apply(input bit rst, input int a0, input int a1, input int a2,
                             input bit we, input int wa, input logic [31:0] wd,
                             input bit ie, input int ia);
    s_reset_n  = rst;
    s_rd_addr  = {5'(a2), 5'(a1), 5'(a0)};
    s_wr_en    = we;
    s_wr_addr  = 5'(wa);
    s_wr_data  = wd;
    s_iss_en   = ie;
    s_iss_addr = 5'(ia);
  endtask

  initial begin
    sweep_apply(1'b0, 0, 0, 0, 1'b0, 0, '0, 1'b0, 0);

    // Reset with a write and issue that must be ignored.
    applyStimulus(1'b0, 3, 0, 1'b1, 5, 64'h1234, 1'b1, 5);
    clock_edge();
    checkOutput("rst_pending", 64'(a_pending), 64'h0);
    applyStimulus(1'b0, 3, 0, 1'b0, 0, '0, 1'b0, 0);
    #2;
    checkOutput("rst_data0", a_rd_data[63:0], 64'h0);
    checkOutput("rst_data1", a_rd_data[127:64], 64'h0);
    checkOutput("rst_ready", 64'(a_rd_ready), 64'h3);
    check_model_reads();
    clock_edge();

    // Write with same-cycle read: bypass vs. no bypass.
    applyStimulus(1'b1, 5, 0, 1'b1, 5, 64'hDEAD_BEEF_0000_0001, 1'b0, 0);
    #2;
    checkOutput("bypass_pre", a_rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    checkOutput("nobyp_pre", b_rd_data[63:0], 64'h0);
    check_model_reads();
    clock_edge();
    applyStimulus(1'b1, 5, 0, 1'b0, 0, '0, 1'b0, 0);
    #2;
    checkOutput("bypass_post", a_rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    checkOutput("nobyp_post", b_rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    clock_edge();

    // Zero register ignores writes and issues.
    applyStimulus(1'b1, 31, 31, 1'b1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 31);
    #2;
    checkOutput("zero_data", a_rd_data[63:0], 64'h0);
    checkOutput("zero_ready", 64'(a_rd_ready[0]), 64'h1);
    clock_edge();
    checkOutput("zero_pending", 64'(a_pending[31]), 64'h0);
    step(1'b1, 31, 5, 1'b0, 0, '0, 1'b0, 0);

    // Scoreboard: issue r7, writeback four cycles later.
    step(1'b1, 7, 7, 1'b0, 0, '0, 1'b1, 7);
    checkOutput("sb_pend_set", 64'(a_pending[7]), 64'h1);
    for (int c = 1; c < 4; c++) begin
      applyStimulus(1'b1, 7, 0, 1'b0, 0, '0, 1'b0, 0);
      #2;
      checkOutput($sformatf("sb_stall_c%0d", c), 64'(a_rd_ready[0]), 64'h0);
      clock_edge();
    end
    applyStimulus(1'b1, 7, 0, 1'b1, 7, 64'h42, 1'b0, 0);
    #2;
    checkOutput("sb_wb_ready", 64'(a_rd_ready[0]), 64'h1);
    checkOutput("sb_wb_data", a_rd_data[63:0], 64'h42);
    checkOutput("sb_wb_nobyp_ready", 64'(b_rd_ready[0]), 64'h0);
    check_model_reads();
    clock_edge();
    checkOutput("sb_pend_clr", 64'(a_pending[7]), 64'h0);

    // Simultaneous write and issue: newer producer wins.
    step(1'b1, 9, 0, 1'b1, 9, 64'h10, 1'b1, 9);
    checkOutput("wi_pend", 64'(a_pending[9]), 64'h1);
    applyStimulus(1'b1, 9, 0, 1'b0, 0, '0, 1'b0, 0);
    #2;
    checkOutput("wi_ready", 64'(a_rd_ready[0]), 64'h0);
    checkOutput("wi_data", a_rd_data[63:0], 64'h10);
    clock_edge();

    // Reset mid-stream beats a write; no forwarding while in reset.
    step(1'b1, 2, 0, 1'b1, 2, 64'h77, 1'b1, 2);
    applyStimulus(1'b0, 2, 0, 1'b1, 2, 64'h99, 1'b0, 0);
    #2;
    checkOutput("rstmid_data", a_rd_data[63:0], 64'h77);
    checkOutput("rstmid_ready", 64'(a_rd_ready[0]), 64'h0);
    check_model_reads();
    clock_edge();
    checkOutput("rstmid_pending", 64'(a_pending), 64'h0);
    applyStimulus(1'b1, 2, 0, 1'b0, 0, '0, 1'b0, 0);
    #2;
    checkOutput("rstmid_lost", a_rd_data[63:0], 64'h0);
    clock_edge();

    // Randomised traffic, addresses biased toward a small set to force hits.
    for (int i = 0; i < 400; i++) begin
      int a0, a1, wa, ia;
      a0 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      wa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      ia = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      step($urandom_range(0, 99) >= 3, a0, a1, $urandom_range(0, 1) != 0, wa,
           {$urandom, $urandom}, $urandom_range(0, 2) == 0, ia);
    end

    // Parameter sweep instance.
    applyStimulus(1'b1, 0, 0, 1'b0, 0, '0, 1'b0, 0);
    @(posedge clk); #1;
    checkOutput("sw_rst_pending", 64'(s_pending), 64'h0);
    sweep_apply(1'b1, 15, 15, 15, 1'b1, 15, 32'hCAFE_F00D, 1'b0, 0);
    #2;
    for (int p = 0; p < 3; p++) begin
      checkOutput($sformatf("sw_byp_data%0d", p), 64'(s_rd_data[p*32 +: 32]), 64'hCAFE_F00D);
      checkOutput($sformatf("sw_byp_rdy%0d", p), 64'(s_rd_ready[p]), 64'h1);
    end
    @(posedge clk); #1;
    sweep_apply(1'b1, 20, 15, 0, 1'b1, 20, 32'h1234, 1'b1, 15);
    #2;
    checkOutput("sw_oob_data", 64'(s_rd_data[31:0]), 64'h0);
    checkOutput("sw_oob_ready", 64'(s_rd_ready[0]), 64'h1);
    checkOutput("sw_r15_data", 64'(s_rd_data[63:32]), 64'hCAFE_F00D);
    checkOutput("sw_r0_data", 64'(s_rd_data[95:64]), 64'h0);
    @(posedge clk); #1;
    checkOutput("sw_pending", 64'(s_pending), 64'h8000);
    sweep_apply(1'b1, 15, 0, 20, 1'b1, 0, 32'h5, 1'b0, 0);
    #2;
    checkOutput("sw_r15_stall", 64'(s_rd_ready[0]), 64'h0);
    checkOutput("sw_r0_byp", 64'(s_rd_data[63:32]), 64'h5);
    @(posedge clk); #1;
    sweep_apply(1'b1, 0, 15, 20, 1'b0, 0, '0, 1'b0, 0);
    #2;
    checkOutput("sw_r0_stored", 64'(s_rd_data[31:0]), 64'h5);
    checkOutput("sw_pending_keep", 64'(s_pending), 64'h8000);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
